// File: rtl/seg7_scan_capture_if.sv
// Scanned 7-segment bus: the multiplexed digit strobe and pattern going in,
// the captured static per-digit patterns and status coming out.
interface seg7_scan_capture_if #(
  parameter int W_DIGIT = 8,
  parameter int W_SEG   = 8
);
  logic [W_SEG-1:0]   hgfedcba;
  logic [W_DIGIT-1:0] digit;
  logic [W_SEG-1:0]   hex [W_DIGIT];
  logic [W_DIGIT-1:0] valid;
  logic               capture;
  logic               scan_err;

  modport master (
    output hgfedcba, digit,
    input  hex, valid, capture, scan_err
  );

  modport slave (
    input  hgfedcba, digit,
    output hex, valid, capture, scan_err
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Recovers static per-digit patterns from a multiplexed 7-segment scan once a pattern holds stable.
// Define SEG7_SCAN_CAPTURE_TIMEOUT_EN to build per-digit expiry of unrefreshed digits.
module seg7_scan_capture #(
  parameter int W_DIGIT        = 8,
  parameter int W_SEG          = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter logic [0:W_DIGIT-1][W_SEG-1:0] R_INIT = '0
) (
  input logic                 clk,
  input logic                 rst,
  seg7_scan_capture_if.slave  scan
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("seg7_scan_capture: STABLE_CYCLES or TIMEOUT_CYCLES out of range");
  end

  localparam int             RW      = 8;
  localparam logic [RW-1:0]  RUN_MAX = RW'(STABLE_CYCLES);

  logic [W_DIGIT-1:0] digit_q, digit_prev_q;
  logic [W_SEG-1:0]   seg_q, seg_prev_q;
  logic               smp_vld_q;
  logic [RW-1:0]      run_q, run_d;
  logic [W_SEG-1:0]   hex_q [W_DIGIT];
  logic [W_SEG-1:0]   hex_d [W_DIGIT];
  logic [W_DIGIT-1:0] valid_q, valid_d;
  logic               capture_q, capture_d;
  logic               scan_err_q, scan_err_d;

  logic               same, new_run, fire, onehot;
  logic [W_DIGIT-1:0] load, expire;

  // A run counts from the first real sample after reset; run_q == 0 means
  // the previous-sample register does not hold a real sample yet.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    run_d   = run_q;
    fire    = 1'b0;
    same    = (seg_q == seg_prev_q) && (digit_q == digit_prev_q);
    new_run = (run_q == '0) || !same;
    onehot  = (digit_q != '0) && ((digit_q & (digit_q - W_DIGIT'(1))) == '0);
    if (smp_vld_q) begin
      if (new_run)                run_d = RW'(1);
      else if (run_q != RUN_MAX)  run_d = run_q + RW'(1);
      fire = new_run ? (RUN_MAX == RW'(1)) : (run_q == RUN_MAX - RW'(1));
    end
  end

  assign load = (fire && onehot) ? digit_q : '0;

`ifdef SEG7_SCAN_CAPTURE_TIMEOUT_EN
  localparam int            AW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] AGE_TRIP = AW'(TIMEOUT_CYCLES - 1);

  logic [AW-1:0] age_q [W_DIGIT];
  logic [AW-1:0] age_d [W_DIGIT];

  always_comb begin
    expire = '0;
    for (int i = 0; i < W_DIGIT; i++) begin
      expire[i] = valid_q[i] && (age_q[i] == AGE_TRIP);
      if (load[i])                  age_d[i] = '0;
      else if (age_q[i] == AGE_MAX) age_d[i] = age_q[i];
      else                          age_d[i] = age_q[i] + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < W_DIGIT; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign expire = '0;
`endif

  // Capture wins over expiry when both hit the same digit on one edge.
  always_comb begin
    hex_d      = hex_q;
    valid_d    = valid_q;
    capture_d  = |load;
    scan_err_d = scan_err_q | (fire & ~onehot);
    for (int i = 0; i < W_DIGIT; i++) begin
      if (load[i]) begin
        hex_d[i]   = seg_q;
        valid_d[i] = 1'b1;
      end else if (expire[i]) begin
        hex_d[i]   = '0;
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q      <= '0;
      digit_prev_q <= '0;
      seg_q        <= '0;
      seg_prev_q   <= '0;
      smp_vld_q    <= 1'b0;
      run_q        <= '0;
      // NOTE: hex is a handful of flops with a per-entry reset value, not a RAM, so resetting every entry is intended.
      for (int i = 0; i < W_DIGIT; i++) hex_q[i] <= R_INIT[i];
      valid_q      <= '0;
      capture_q    <= 1'b0;
      scan_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see the pre-edge values, which the sample/previous pipeline relies on.
      digit_q      <= scan.digit;
      seg_q        <= scan.hgfedcba;
      digit_prev_q <= digit_q;
      seg_prev_q   <= seg_q;
      smp_vld_q    <= 1'b1;
      run_q        <= run_d;
      hex_q        <= hex_d;
      valid_q      <= valid_d;
      capture_q    <= capture_d;
      scan_err_q   <= scan_err_d;
    end
  end

  assign scan.hex      = hex_q;
  assign scan.valid    = valid_q;
  assign scan.capture  = capture_q;
  assign scan.scan_err = scan_err_q;

endmodule
